// File: rtl/stopwatch_pkg.sv
// Shared definitions for the stopwatch controller: state encoding, display
// constants and default parameter values. Also used by the top-level display mux.
package stopwatch_pkg;

    // Operating states of the stopwatch sequencer.
    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_RUN       = 3'd1,
        ST_PAUSE     = 3'd2,
        ST_LAP_RUN   = 3'd3,
        ST_LAP_PAUSE = 3'd4
    } sw_state_e;

    // seven_seg_fsm mode selecting the mm:ss.fff time format
    localparam logic [1:0]  MODE_TIME     = 2'd2;

    localparam int unsigned COUNT_W_DFLT  = 39;
    localparam int unsigned MAX_MS_DFLT   = 3599999;   // 59:59.999
    localparam int unsigned BLINK_MS_DFLT = 500;
    localparam logic [7:0]  DECS_DEF_DFLT = 8'b00101000;

    // States in which the millisecond counter advances.
    function automatic logic is_counting(input sw_state_e s);
        return (s == ST_RUN) || (s == ST_LAP_RUN);
    endfunction

    // States in which the decimal points blink.
    function automatic logic is_paused(input sw_state_e s);
        return (s == ST_PAUSE) || (s == ST_LAP_PAUSE);
    endfunction

    // States in which the display shows the frozen lap value.
    function automatic logic is_lap(input sw_state_e s);
        return (s == ST_LAP_RUN) || (s == ST_LAP_PAUSE);
    endfunction

endpackage

// File: rtl/stopwatch_blink_gen.sv
// Blink phase generator for the paused display. Counts ms strobes while
// enabled and toggles the phase every BLINK_MS strobes. Restart forces the
// counter to 0 and the phase to 1 (points lit). The next-state phase is also
// exported so the parent can register its decimal-point output in step.
module stopwatch_blink_gen #(
    parameter int unsigned BLINK_MS = 500
) (
    input  logic clock,
    input  logic reset,
    input  logic ms_tick,
    input  logic enable,
    input  logic restart,
    output logic phase,
    output logic phase_next
);

    localparam int unsigned   CNT_W = $clog2(BLINK_MS + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BLINK_MS - 1);

    logic [CNT_W-1:0] blink_cnt_q, blink_cnt_d;
    logic             phase_q, phase_d;

    // Next-state: restart dominates, otherwise advance on each ms strobe.
    always_comb begin
        blink_cnt_d = blink_cnt_q;
        phase_d     = phase_q;
        if (restart) begin
            blink_cnt_d = '0;
            phase_d     = 1'b1;
        end else if (enable && ms_tick) begin
            if (blink_cnt_q == CNT_LAST) begin
                blink_cnt_d = '0;
                phase_d     = ~phase_q;
            end else begin
                blink_cnt_d = blink_cnt_q + CNT_W'(1);
            end
        end
    end

    // Counter and phase registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            blink_cnt_q <= '0;
            phase_q     <= 1'b1;
        end else begin
            blink_cnt_q <= blink_cnt_d;
            phase_q     <= phase_d;
        end
    end

    assign phase      = phase_q;
    assign phase_next = phase_d;

endmodule

// File: rtl/stopwatch_controller.sv
// Stopwatch sequencer: start/stop, lap freeze and clear from debounced button
// pulses; counts 1 ms strobes and drives value, mode and decimal points for
// seven_seg_fsm. Lap support is compiled in with `STOPWATCH_LAP_EN.
// All outputs come straight from flops, loaded from next-state values so an
// input sampled at one edge is visible right after that edge.
module stopwatch_controller
    import stopwatch_pkg::*;
#(
    parameter int unsigned COUNT_W  = COUNT_W_DFLT,
    parameter int unsigned MAX_MS   = MAX_MS_DFLT,
    parameter int unsigned BLINK_MS = BLINK_MS_DFLT,
    parameter logic [7:0]  DECS_DEF = DECS_DEF_DFLT
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               ms_tick,
    input  logic               btn_ss,
    input  logic               btn_lap,
    input  logic               btn_clr,
    output logic [COUNT_W-1:0] disp_value,
    output logic [1:0]         disp_mode,
    output logic [7:0]         disp_decs,
    output logic               running,
    output logic               lap_active,
    output logic               overflow
);

    localparam logic [COUNT_W-1:0] COUNT_MAX = COUNT_W'(MAX_MS);

    sw_state_e          state_q, state_d;
    logic [COUNT_W-1:0] count_q, count_d;
    logic               overflow_q, overflow_d;
    logic [COUNT_W-1:0] lap_val_q, lap_val_d;
    logic               lap_req;

    logic [COUNT_W-1:0] disp_value_q;
    logic [7:0]         disp_decs_q;
    logic               running_q;
    logic               lap_active_q;

    logic               blink_enable;
    logic               blink_restart;
    logic               blink_phase;
    logic               blink_phase_d;

`ifdef STOPWATCH_LAP_EN
    assign lap_req = btn_lap;
`else
    logic unused_btn_lap;
    assign unused_btn_lap = btn_lap;
    assign lap_req        = 1'b0;
`endif

    // FSM next state; clear beats start/stop beats lap, one transition per cycle.
    always_comb begin
        state_d = state_q;
        if (btn_clr) begin
            state_d = ST_IDLE;
        end else if (btn_ss) begin
            case (state_q)
                ST_IDLE:      state_d = ST_RUN;
                ST_RUN:       state_d = ST_PAUSE;
                ST_PAUSE:     state_d = ST_RUN;
`ifdef STOPWATCH_LAP_EN
                ST_LAP_RUN:   state_d = ST_LAP_PAUSE;
                ST_LAP_PAUSE: state_d = ST_LAP_RUN;
`endif
                default:      state_d = ST_IDLE;
            endcase
        end else if (lap_req) begin
            case (state_q)
                ST_RUN:       state_d = ST_LAP_RUN;
                ST_LAP_RUN:   state_d = ST_RUN;
                ST_LAP_PAUSE: state_d = ST_PAUSE;
                default:      state_d = state_q;
            endcase
        end
    end

    // FSM state register.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Millisecond counter: advances on the current state, so a tick arriving
    // with the stop press still counts and one arriving with a clear is lost.
    always_comb begin
        count_d    = count_q;
        overflow_d = overflow_q;
        if (btn_clr) begin
            count_d    = '0;
            overflow_d = 1'b0;
        end else if (ms_tick && is_counting(state_q)) begin
            if (count_q == COUNT_MAX) begin
                count_d    = '0;
                overflow_d = 1'b1;
            end else begin
                count_d = count_q + COUNT_W'(1);
            end
        end
    end

    // Counter and sticky overflow registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

`ifdef STOPWATCH_LAP_EN
    // Lap latch captures the pre-tick count on entry to LAP_RUN from RUN.
    always_comb begin
        lap_val_d = lap_val_q;
        if (btn_clr) begin
            lap_val_d = '0;
        end else if ((state_q == ST_RUN) && (state_d == ST_LAP_RUN)) begin
            lap_val_d = count_q;
        end
    end

    // Lap value register.
    always_ff @(posedge clock) begin
        if (reset) begin
            lap_val_q <= '0;
        end else begin
            lap_val_q <= lap_val_d;
        end
    end
`else
    assign lap_val_d = '0;
    assign lap_val_q = '0;
`endif

    // Blink restarts on every entry into a paused state (including the
    // LAP_PAUSE -> PAUSE hop) and is held at phase 1 everywhere else.
    assign blink_enable  = is_paused(state_q);
    assign blink_restart = !is_paused(state_d) || (state_d != state_q);

    stopwatch_blink_gen #(
        .BLINK_MS (BLINK_MS)
    ) u_blink (
        .clock      (clock),
        .reset      (reset),
        .ms_tick    (ms_tick),
        .enable     (blink_enable),
        .restart    (blink_restart),
        .phase      (blink_phase),
        .phase_next (blink_phase_d)
    );

    // Output registers loaded from next-state values.
    always_ff @(posedge clock) begin
        if (reset) begin
            disp_value_q <= '0;
            disp_decs_q  <= DECS_DEF;
            running_q    <= 1'b0;
            lap_active_q <= 1'b0;
        end else begin
            disp_value_q <= is_lap(state_d) ? lap_val_d : count_d;
            disp_decs_q  <= (is_paused(state_d) && !blink_phase_d) ? 8'h00 : DECS_DEF;
            running_q    <= is_counting(state_d);
            lap_active_q <= is_lap(state_d);
        end
    end

    logic unused_blink_phase;
    assign unused_blink_phase = blink_phase;

    assign disp_value = disp_value_q;
    assign disp_mode  = MODE_TIME;
    assign disp_decs  = disp_decs_q;
    assign running    = running_q;
    assign lap_active = lap_active_q;
    assign overflow   = overflow_q;

endmodule

// File: tb/tb_stopwatch_controller.sv
// Testbench for stopwatch_controller: directed scenarios followed by random
// button/tick traffic, each cycle checked against a behavioural model.
// Follows `STOPWATCH_LAP_EN the same way as the design.
module tb_stopwatch_controller;

    localparam int unsigned TB_COUNT_W = 39;
    localparam int unsigned TB_MAX     = 2999;     // shortened wrap point
    localparam int unsigned TB_BLINK   = 500;
    localparam logic [7:0]  TB_DECS    = 8'b00101000;
`ifdef STOPWATCH_LAP_EN
    localparam bit LAP_EN = 1'b1;
`else
    localparam bit LAP_EN = 1'b0;
`endif

    logic                  clock = 1'b0;
    logic                  reset = 1'b1;
    logic                  ms_tick = 1'b0;
    logic                  btn_ss = 1'b0;
    logic                  btn_lap = 1'b0;
    logic                  btn_clr = 1'b0;
    logic [TB_COUNT_W-1:0] disp_value;
    logic [1:0]            disp_mode;
    logic [7:0]            disp_decs;
    logic                  running;
    logic                  lap_active;
    logic                  overflow;

    int n_checks = 0;
    int n_errors = 0;

    // Behavioural model: plain flags and integers.
    bit      m_idle, m_run, m_lap, m_ovf;
    longint  m_count, m_lapv;
    int      m_pticks;      // ms ticks since entering the current pause

    always #5 clock = ~clock;

    stopwatch_controller #(
        .COUNT_W  (TB_COUNT_W),
        .MAX_MS   (TB_MAX),
        .BLINK_MS (TB_BLINK),
        .DECS_DEF (TB_DECS)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .ms_tick    (ms_tick),
        .btn_ss     (btn_ss),
        .btn_lap    (btn_lap),
        .btn_clr    (btn_clr),
        .disp_value (disp_value),
        .disp_mode  (disp_mode),
        .disp_decs  (disp_decs),
        .running    (running),
        .lap_active (lap_active),
        .overflow   (overflow)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_step(input bit r, input bit c, input bit s, input bit l, input bit t);
        longint old_count;
        bit     paused_now;
        if (r) begin
            m_idle = 1; m_run = 0; m_lap = 0; m_ovf = 0;
            m_count = 0; m_lapv = 0; m_pticks = 0;
        end else if (c) begin
            m_idle = 1; m_run = 0; m_lap = 0; m_ovf = 0;
            m_count = 0; m_lapv = 0; m_pticks = 0;
        end else begin
            old_count  = m_count;
            paused_now = !m_idle && !m_run;
            if (t && m_run) begin
                if (m_count == longint'(TB_MAX)) begin
                    m_count = 0;
                    m_ovf   = 1;
                end else begin
                    m_count++;
                end
            end
            if (t && paused_now) m_pticks++;
            if (s) begin
                if (m_idle) begin
                    m_idle = 0;
                    m_run  = 1;
                end else begin
                    m_run = !m_run;
                    if (!m_run) m_pticks = 0;
                end
            end else if (l && LAP_EN && !m_idle) begin
                if (m_run) begin
                    if (!m_lap) begin
                        m_lapv = old_count;
                        m_lap  = 1;
                    end else begin
                        m_lap = 0;
                    end
                end else if (m_lap) begin
                    m_lap    = 0;
                    m_pticks = 0;
                end
            end
        end
    endtask

    task automatic check_outputs();
        logic [7:0] exp_decs;
        exp_decs = (!m_idle && !m_run && (((m_pticks / TB_BLINK) % 2) == 1)) ? 8'h00 : TB_DECS;
        chk("disp_value", 64'(disp_value), 64'(m_lap ? m_lapv : m_count));
        chk("disp_mode",  64'(disp_mode),  64'(2));
        chk("disp_decs",  64'(disp_decs),  64'(exp_decs));
        chk("running",    64'(running),    64'(m_run));
        chk("lap_active", 64'(lap_active), 64'(m_lap));
        chk("overflow",   64'(overflow),   64'(m_ovf));
    endtask

    task automatic step(input bit r, input bit c, input bit s, input bit l, input bit t);
        @(negedge clock);
        reset = r; btn_clr = c; btn_ss = s; btn_lap = l; ms_tick = t;
        @(posedge clock);
        model_step(r, c, s, l, t);
        #1;
        check_outputs();
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 1);
    endtask

    initial begin
        model_step(1, 0, 0, 0, 0);

        // reset values
        step(1, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0);
        chk("rst_value", 64'(disp_value), 64'(0));
        chk("rst_decs",  64'(disp_decs),  64'(TB_DECS));
        chk("rst_run",   64'(running),    64'(0));

        // 1: run 1500 ms, stop, value frozen
        step(0, 0, 1, 0, 0);
        chk("t1_running", 64'(running), 64'(1));
        ticks(1500);
        step(0, 0, 1, 0, 0);
        chk("t1_stopped", 64'(running), 64'(0));
        chk("t1_value", 64'(disp_value), 64'(1500));
        ticks(50);
        chk("t1_frozen", 64'(disp_value), 64'(1500));

        // 2: blink while paused, fresh pause entry
        step(0, 0, 1, 0, 0);
        step(0, 0, 1, 0, 0);
        for (int i = 1; i <= 1200; i++) begin
            step(0, 0, 0, 0, 1);
            if (i == 499)  chk("t2_lit_499",  64'(disp_decs), 64'(TB_DECS));
            if (i == 500)  chk("t2_dark_500", 64'(disp_decs), 64'(8'h00));
            if (i == 999)  chk("t2_dark_999", 64'(disp_decs), 64'(8'h00));
            if (i == 1000) chk("t2_lit_1000", 64'(disp_decs), 64'(TB_DECS));
        end
        step(0, 0, 0, 0, 0);
        ticks(300);
        chk("t2_dark_1500", 64'(disp_decs), 64'(8'h00));
        step(0, 0, 1, 0, 0);
        chk("t2_resume_lit", 64'(disp_decs), 64'(TB_DECS));

        // 3: lap freeze and release
        step(0, 1, 0, 0, 0);
        step(0, 0, 1, 0, 0);
        ticks(2000);
        step(0, 0, 0, 1, 0);
        ticks(300);
        chk("t3_lap_value", 64'(disp_value), 64'(LAP_EN ? 2000 : 2300));
        chk("t3_lap_active", 64'(lap_active), 64'(LAP_EN));
        step(0, 0, 0, 1, 0);
        chk("t3_live_value", 64'(disp_value), 64'(2300));

        // 4: wrap at the last count
        step(0, 1, 0, 0, 0);
        step(0, 0, 1, 0, 0);
        ticks(TB_MAX);
        chk("t4_at_max", 64'(disp_value), 64'(TB_MAX));
        chk("t4_no_ovf", 64'(overflow), 64'(0));
        ticks(1);
        chk("t4_wrapped", 64'(disp_value), 64'(0));
        chk("t4_ovf", 64'(overflow), 64'(1));
        ticks(5);
        chk("t4_after5", 64'(disp_value), 64'(5));
        chk("t4_ovf_sticky", 64'(overflow), 64'(1));

        // 5: clear beats start/stop and tick
        ticks(695);
        chk("t5_at700", 64'(disp_value), 64'(700));
        step(0, 1, 1, 0, 1);
        chk("t5_value", 64'(disp_value), 64'(0));
        chk("t5_ovf", 64'(overflow), 64'(0));
        chk("t5_running", 64'(running), 64'(0));

        // 6: reset during (lap) pause with tick and lap
        step(0, 0, 1, 0, 0);
        ticks(100);
        step(0, 0, 0, 1, 0);
        step(0, 0, 1, 0, 0);
        ticks(600);
        step(1, 0, 0, 1, 1);
        chk("t6_value", 64'(disp_value), 64'(0));
        chk("t6_decs", 64'(disp_decs), 64'(TB_DECS));
        chk("t6_lap", 64'(lap_active), 64'(0));
        chk("t6_running", 64'(running), 64'(0));

        // random traffic
        for (int i = 0; i < 6000; i++) begin
            step($urandom_range(0, 999) == 0,
                 $urandom_range(0, 299) == 0,
                 $urandom_range(0, 39) == 0,
                 $urandom_range(0, 29) == 0,
                 $urandom_range(0, 1) == 1);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
